axi4lite_master_sequencer: RTL and testbench

Turns a simple one-shot command/response interface into fully sequenced AXI4-Lite master

---
 rtl/axi4lite_master_sequencer_if.sv | 37 +++
 rtl/axi4lite_master_sequencer.sv | 158 +++++++++++++++
 tb/tb_axi4lite_master_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_master_sequencer_if.sv
// AXI4-Lite master-side channel bundle (AW/W/B/AR/R) with master and slave views.
interface axi4lite_master_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  AWVALID;
    logic                  AWREADY;
    logic [ADDR_W-1:0]     AWADDR;
    logic [2:0]            AWPROT;
    logic                  WVALID;
    logic                  WREADY;
    logic [DATA_W-1:0]     WDATA;
    logic [DATA_W/8-1:0]   WSTRB;
    logic                  BVALID;
    logic                  BREADY;
    logic [1:0]            BRESP;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [ADDR_W-1:0]     ARADDR;
    logic [2:0]            ARPROT;
    logic                  RVALID;
    logic                  RREADY;
    logic [DATA_W-1:0]     RDATA;
    logic [1:0]            RRESP;

    modport master (
        output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, ARPROT, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, ARPROT, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi4lite_master_sequencer.sv
// One-outstanding AXI4-Lite master: a command/response client port sequenced onto AW/W/B or AR/R.
// Every output is a flop; the comb process only computes next values.
module axi4lite_master_sequencer #(
    parameter int          ADDR_W = 32,
    parameter int          DATA_W = 32,
    parameter logic [2:0]  PROT   = 3'b000
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [DATA_W-1:0]    cmd_wdata,
    input  logic [DATA_W/8-1:0]  cmd_wstrb,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic [1:0]           rsp_resp,
    axi4lite_master_sequencer_if.master axi
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, WADDR_DATA, WRESP, RADDR, RDATA, RESP} state_t;

    state_t               state, state_nxt;
    logic                 awvalid, wvalid, bready, arvalid, rready;
    logic                 awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
    logic                 cmd_ready_nxt, rsp_valid_nxt;
    logic [ADDR_W-1:0]    addr, addr_nxt;
    logic [DATA_W-1:0]    wdata, wdata_nxt, rdata_nxt;
    logic [STRB_W-1:0]    wstrb, wstrb_nxt;
    logic [1:0]           resp_nxt;
    logic [2:0]           prot;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            prot      <= '0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= cmd_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rdata_nxt;
            rsp_resp  <= resp_nxt;
            awvalid   <= awvalid_nxt;
            wvalid    <= wvalid_nxt;
            bready    <= bready_nxt;
            arvalid   <= arvalid_nxt;
            rready    <= rready_nxt;
            addr      <= addr_nxt;
            wdata     <= wdata_nxt;
            wstrb     <= wstrb_nxt;
            prot      <= PROT;
        end
    end

    always_comb begin
        state_nxt     = state;
        cmd_ready_nxt = cmd_ready;
        rsp_valid_nxt = rsp_valid;
        rdata_nxt     = rsp_rdata;
        resp_nxt      = rsp_resp;
        awvalid_nxt   = awvalid;
        wvalid_nxt    = wvalid;
        bready_nxt    = bready;
        arvalid_nxt   = arvalid;
        rready_nxt    = rready;
        addr_nxt      = addr;
        wdata_nxt     = wdata;
        wstrb_nxt     = wstrb;
        case (state)
            IDLE: begin
                cmd_ready_nxt = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    cmd_ready_nxt = 1'b0;
                    addr_nxt      = cmd_addr;
                    wdata_nxt     = cmd_wdata;
                    wstrb_nxt     = cmd_wstrb;
                    if (cmd_write) begin
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        state_nxt   = WADDR_DATA;
                    end else begin
                        arvalid_nxt = 1'b1;
                        state_nxt   = RADDR;
                    end
                end
            end
            WADDR_DATA: begin
                // AW and W retire independently; leave once neither is still pending.
                if (awvalid && axi.AWREADY) awvalid_nxt = 1'b0;
                if (wvalid && axi.WREADY)   wvalid_nxt  = 1'b0;
                if ((!awvalid || axi.AWREADY) && (!wvalid || axi.WREADY)) begin
                    bready_nxt = 1'b1;
                    state_nxt  = WRESP;
                end
            end
            WRESP: begin
                if (axi.BVALID) begin
                    resp_nxt      = axi.BRESP;
                    rdata_nxt     = '0;
                    bready_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end
            end
            RADDR: begin
                if (axi.ARREADY) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = RDATA;
                end
            end
            RDATA: begin
                if (axi.RVALID) begin
                    rdata_nxt     = axi.RDATA;
                    resp_nxt      = axi.RRESP;
                    rready_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    cmd_ready_nxt = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign axi.AWVALID = awvalid;
    assign axi.AWADDR  = addr;
    assign axi.AWPROT  = prot;
    assign axi.WVALID  = wvalid;
    assign axi.WDATA   = wdata;
    assign axi.WSTRB   = wstrb;
    assign axi.BREADY  = bready;
    assign axi.ARVALID = arvalid;
    assign axi.ARADDR  = addr;
    assign axi.ARPROT  = prot;
    assign axi.RREADY  = rready;
endmodule

// File: tb/tb_axi4lite_master_sequencer.sv
// Directed + random bench: delay-programmable slave, expectations from handshake-count arithmetic.
module tb_axi4lite_master_sequencer;
    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready;
    logic [31:0] cmd_addr, cmd_wdata, rsp_rdata;
    logic [3:0]  cmd_wstrb;
    logic [1:0]  rsp_resp;

    int n_chk = 0;
    int n_fail = 0;
    // slave behaviour for the current transaction
    int aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0;
    logic [1:0]  b_resp = 2'b00, r_resp = 2'b00;
    logic [31:0] r_data = '0;

    axi4lite_master_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi4lite_master_sequencer #(.ADDR_W(32), .DATA_W(32), .PROT(3'b000)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .axi(bus.master)
    );

    initial forever #5 ACLK = ~ACLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Slave channels: each READY/VALID is raised <delay> cycles after the trigger is first seen.
    initial begin
        bus.AWREADY = 1'b0;
        forever begin
            @(negedge ACLK);
            if (bus.AWVALID) begin
                repeat (aw_d) @(negedge ACLK);
                bus.AWREADY = 1'b1; @(posedge ACLK); #1 bus.AWREADY = 1'b0;
            end
        end
    end
    initial begin
        bus.WREADY = 1'b0;
        forever begin
            @(negedge ACLK);
            if (bus.WVALID) begin
                repeat (w_d) @(negedge ACLK);
                bus.WREADY = 1'b1; @(posedge ACLK); #1 bus.WREADY = 1'b0;
            end
        end
    end
    initial begin
        bus.BVALID = 1'b0; bus.BRESP = 2'b00;
        forever begin
            @(negedge ACLK);
            if (bus.BREADY) begin
                repeat (b_d) @(negedge ACLK);
                bus.BVALID = 1'b1; bus.BRESP = b_resp;
                @(posedge ACLK); #1 bus.BVALID = 1'b0; bus.BRESP = 2'b00;
            end
        end
    end
    initial begin
        bus.ARREADY = 1'b0;
        forever begin
            @(negedge ACLK);
            if (bus.ARVALID) begin
                repeat (ar_d) @(negedge ACLK);
                bus.ARREADY = 1'b1; @(posedge ACLK); #1 bus.ARREADY = 1'b0;
            end
        end
    end
    initial begin
        bus.RVALID = 1'b0; bus.RDATA = '0; bus.RRESP = 2'b00;
        forever begin
            @(negedge ACLK);
            if (bus.RREADY) begin
                repeat (r_d) @(negedge ACLK);
                bus.RVALID = 1'b1; bus.RDATA = r_data; bus.RRESP = r_resp;
                @(posedge ACLK); #1 bus.RVALID = 1'b0; bus.RDATA = '0; bus.RRESP = 2'b00;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic any_output();
        return |{cmd_ready, rsp_valid, rsp_rdata, rsp_resp, bus.AWVALID, bus.AWADDR, bus.AWPROT,
                 bus.WVALID, bus.WDATA, bus.WSTRB, bus.BREADY, bus.ARVALID, bus.ARADDR,
                 bus.ARPROT, bus.RREADY};
    endfunction

    // One complete transaction; entered and left just after a falling edge.
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int hold, input logic keep);
        int n, lat, aw_c, w_c, ar_c, br_first, rr_first, exp_lat, wmax;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        wmax      = (aw_d > w_d) ? aw_d : w_d;
        exp_lat   = wr ? 3 + wmax + b_d : 3 + ar_d + r_d;
        exp_rdata = wr ? 32'h0 : r_data;
        exp_resp  = wr ? b_resp : r_resp;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 64) begin @(negedge ACLK); n++; end
        chk("accept_within_bound", 64'(n < 64), 64'd1);
        @(posedge ACLK); #1;
        if (!keep) cmd_valid = 1'b0;
        chk("cmd_ready_drops_on_accept", 64'(cmd_ready), 64'd0);
        lat = 0; aw_c = 0; w_c = 0; ar_c = 0; br_first = 0; rr_first = 0;
        while (lat < 64) begin
            @(negedge ACLK); lat++;
            if (bus.AWVALID) begin
                aw_c++;
                chk("awaddr_stable", 64'(bus.AWADDR), 64'(addr));
                chk("awprot", 64'(bus.AWPROT), 64'd0);
            end
            if (bus.WVALID) begin
                w_c++;
                chk("wdata_stable", 64'({bus.WSTRB, bus.WDATA}), 64'({strb, wdata}));
            end
            if (bus.ARVALID) begin
                ar_c++;
                chk("araddr_stable", 64'(bus.ARADDR), 64'(addr));
            end
            if (bus.BREADY && br_first == 0) br_first = lat;
            if (bus.RREADY && rr_first == 0) rr_first = lat;
            if (rsp_valid) break;
        end
        chk("rsp_latency", 64'(lat), 64'(exp_lat));
        chk("aw_valid_cycles", 64'(aw_c), wr ? 64'(aw_d + 1) : 64'd0);
        chk("w_valid_cycles", 64'(w_c), wr ? 64'(w_d + 1) : 64'd0);
        chk("ar_valid_cycles", 64'(ar_c), wr ? 64'd0 : 64'(ar_d + 1));
        chk("bready_first_cycle", 64'(br_first), wr ? 64'(wmax + 2) : 64'd0);
        chk("rready_first_cycle", 64'(rr_first), wr ? 64'd0 : 64'(ar_d + 2));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
        chk("rsp_resp", 64'(rsp_resp), 64'(exp_resp));
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            chk("hold_rsp", 64'({rsp_valid, cmd_ready, rsp_resp, rsp_rdata}),
                64'({1'b1, 1'b0, exp_resp, exp_rdata}));
        end
        rsp_ready = 1'b1;
        @(posedge ACLK); #1 rsp_ready = 1'b0;
        chk("rsp_handshake_done", 64'({rsp_valid, cmd_ready}), 64'b01);
        @(negedge ACLK);
    endtask

    initial begin
        ARESETn = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        #1 chk("reset_outputs_zero", 64'(any_output()), 64'd0);
        repeat (2) @(posedge ACLK);
        @(negedge ACLK) ARESETn = 1'b1;
        #1 chk("cmd_ready_low_before_edge", 64'(cmd_ready), 64'd0);
        @(posedge ACLK); #1 chk("cmd_ready_after_release", 64'(cmd_ready), 64'd1);
        @(negedge ACLK);

        // zero-wait write, then AW delayed, then W delayed
        b_resp = 2'b00;
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
        aw_d = 4; w_d = 0;
        txn(1'b1, 32'h14, 32'hCAFEF00D, 4'h3, 0, 1'b0);
        aw_d = 0; w_d = 4; b_resp = 2'b11;
        txn(1'b1, 32'h18, 32'h0BADF00D, 4'hC, 0, 1'b0);
        w_d = 0;

        // read with slow RVALID and SLVERR
        r_d = 3; r_data = 32'h12345678; r_resp = 2'b10;
        txn(1'b0, 32'h24, 32'h0, 4'h0, 0, 1'b0);
        r_d = 0;

        // response held off while the client keeps presenting the next command
        r_data = 32'hA5A5_0001; r_resp = 2'b01;
        txn(1'b0, 32'h80, 32'h0, 4'h0, 6, 1'b1);
        r_data = 32'hA5A5_0002; r_resp = 2'b00;
        txn(1'b0, 32'h80, 32'h0, 4'h0, 0, 1'b0);

        // reset while AW/W are outstanding
        aw_d = 20; w_d = 20;
        cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'hF;
        cmd_valid = 1'b1;
        @(posedge ACLK); #1 cmd_valid = 1'b0;
        repeat (2) @(negedge ACLK);
        chk("mid_write_valids", 64'({bus.AWVALID, bus.WVALID}), 64'b11);
        #2 ARESETn = 1'b0;
        #1 chk("async_reset_outputs_zero", 64'(any_output()), 64'd0);
        @(posedge ACLK); @(negedge ACLK) ARESETn = 1'b1;
        #1 chk("post_reset_cmd_ready_low", 64'(cmd_ready), 64'd0);
        @(posedge ACLK); #1 chk("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
        for (int i = 0; i < 30; i++) begin
            @(negedge ACLK);
            chk("no_stray_activity",
                64'({rsp_valid, bus.AWVALID, bus.WVALID, bus.BREADY, cmd_ready}), 64'b00001);
        end
        aw_d = 0; w_d = 0;

        for (int t = 0; t < 24; t++) begin
            logic wr;
            logic [31:0] a, d;
            logic [3:0] s;
            wr = 1'($urandom_range(0, 1));
            a = $urandom & 32'hFFFF_FFFC;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            aw_d = $urandom_range(0, 3); w_d = $urandom_range(0, 3); b_d = $urandom_range(0, 3);
            ar_d = $urandom_range(0, 3); r_d = $urandom_range(0, 3);
            b_resp = 2'($urandom_range(0, 3)); r_resp = 2'($urandom_range(0, 3));
            r_data = $urandom;
            txn(wr, a, d, s, $urandom_range(0, 2), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
